// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational
// instruction memory into a 2-entry buffer, and hands entries to decode over
// a valid/ready handshake. Redirects flush the buffer and reload the PC. A
// misaligned or out-of-range PC halts fetching and raises fault.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   imem_addr         byte address to instruction memory (the PC register)
//   imem_instr        instruction word at imem_addr, same cycle
//   redirect_valid/pc branch/jump redirect request and target
//   out_valid/ready   decode handshake; out_instr/out_pc are the buffer head
//   fault/fault_pc    fetch halted, and the PC that caused it
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  // One past the last valid byte address, widened so the compare cannot wrap.
  localparam logic [32:0] IM_END = 33'(IM_BASE) + (33'(IM_WORDS) << 2);

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic               fault_q, fault_d;
  logic [31:0]        fault_pc_q, fault_pc_d;
  logic [31:0]        buf_pc_q    [DEPTH];
  logic [31:0]        buf_instr_q [DEPTH];

  logic               pop;
  logic               push;
  logic               space;
  logic               bad;
  logic [32:0]        pc_ext;

  assign imem_addr = pc_q;
  assign out_valid = (cnt_q != '0);
  assign out_instr = buf_instr_q[head_q];
  assign out_pc    = buf_pc_q[head_q];
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  assign pc_ext = {1'b0, pc_q};
  assign bad    = (pc_q[1:0] != 2'b00) | (pc_ext < 33'(IM_BASE)) | (pc_ext >= IM_END);
  assign pop    = out_valid & out_ready;
  assign space  = (cnt_q < CNT_W'(DEPTH)) | pop;

  // Next-state: fetch/fault decisions, then redirect overrides, then buffer pointers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;

    case (state_q)
      RUN: begin
        if (!redirect_valid && space) begin
          if (bad) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
      end
      FAULT: begin
      end
      default: state_d = RUN;
    endcase

    if (redirect_valid) begin
      // Flush: any pop this cycle still completes on the decode side.
      state_d = RUN;
      fault_d = 1'b0;
      pc_d    = redirect_pc;
      cnt_d   = '0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Buffer payload; contents are qualified by cnt_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_pc_q[tail_q]    <= pc_q;
      buf_instr_q[tail_q] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_ifetch_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam longint      LIMIT = 64'h3000 + 4 * 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  function automatic bit is_bad(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a % 4 != 0) || (la < longint'(BASE)) || (la >= LIMIT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
  endtask

  // Apply one clock edge to the reference model using the driven inputs.
  task automatic model_edge();
    bit pop;
    bit space;
    pop   = (m_q.size() != 0) && out_ready;
    space = (m_q.size() < 2) || pop;
    if (reset) begin
      m_q.delete();
      m_pc       = BASE;
      m_fault    = 1'b0;
      m_fault_pc = '0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc;
      m_fault = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_fault && space) begin
        if (is_bad(m_pc)) begin
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
        end else begin
          m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0: return BASE + 32'(($urandom_range(0, 4095)) << 2);
      1: return 32'h0000_6FF0 + 32'(($urandom_range(0, 3)) << 2);
      2: return BASE + 32'($urandom_range(0, 64));
      3: return 32'h0000_2FFC;
      4: return 32'hFFFF_FFFC;
      default: return 32'h0000_3000 + 32'(($urandom_range(0, 15)) << 2);
    endcase
  endfunction

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset then stream with out_ready high.
    step(1, 0, 0, 1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_addr", imem_addr, 32'h3000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Stall: buffer fills, pc stops at 0x3008.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_addr", imem_addr, 32'h3008);
    chk("stall_head", out_pc, 32'h3000);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Redirect while full with a pop.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h3100, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("redir_pc", out_pc, 32'h3100);
    step(0, 0, 0, 1);

    // Run off the end of memory.
    step(0, 1, 32'h6FF0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h7000);
    chk("end_drained", 32'(out_valid), 32'd0);

    // Recover from fault, then fault on misaligned target.
    step(0, 1, 32'h3000, 1);
    chk("recover_fault", 32'(fault), 32'd0);
    step(0, 0, 0, 1);
    step(0, 1, 32'h3002, 1);
    step(0, 0, 0, 1);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h3002);

    // Reset during fault with one entry buffered.
    step(0, 1, 32'h6FFC, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_fault", 32'(fault), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    step(1, 0, 0, 0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rst, rv, rdy;
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(rst, rv, rand_target(), rdy);
    end
    step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
